// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: queues BPU predictions, checks them
// against resolved outcomes, and drives counter feedback and redirects.
package core_config_pkg;
  parameter int XLEN = 32;
  typedef enum logic [3:0] {
    OP_NOP, OP_LUI, OP_AUIPC,
    OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT,
    OP_BGE, OP_BLTU, OP_BGEU,
    OP_LOAD, OP_STORE,
    OP_ALU, OP_ALUI
  } opcodes_t;
endpackage

module branch_resolve
  import core_config_pkg::*;
#(
  parameter int XLEN  = core_config_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  input  logic [XLEN-1:0]         pred_target,
  output logic                    pred_ready,
  input  logic                    res_valid,
  input  opcodes_t                res_instr,
  input  logic [XLEN-1:0]         res_pc,
  input  logic [XLEN-1:0]         res_imm,
  input  logic [XLEN-1:0]         res_rs1,
  input  logic                    res_cond,
  output logic                    res_ready,
  output logic                    predict_ok,
  output logic                    mispredict,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    redirect_write,
  output logic                    pipe_flush,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REPORT,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic            taken_mem  [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];

  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            wrong_q;
  logic            cond_q;
  logic [XLEN-1:0] redirect_q;

  logic            is_cf;
  logic            is_br;
  logic            act_taken;
  logic [XLEN-1:0] act_target;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] pc_4;
  logic [XLEN-1:0] jalr_sum;

  logic            empty;
  logic            full;
  logic            head_taken;
  logic [XLEN-1:0] head_target;
  logic            wrong;

  logic            accept;
  logic            report;
  logic            clear;
  logic            push;
  logic            pop;

  assign pc_imm   = res_pc + res_imm;
  assign pc_4     = res_pc + XLEN'(4);
  assign jalr_sum = res_rs1 + res_imm;

  always_comb begin
    is_cf      = 1'b0;
    is_br      = 1'b0;
    act_taken  = 1'b0;
    act_target = pc_4;
    unique case (res_instr)
      OP_JAL: begin
        is_cf      = 1'b1;
        act_taken  = 1'b1;
        act_target = pc_imm;
      end
      OP_JALR: begin
        is_cf      = 1'b1;
        act_taken  = 1'b1;
        act_target = jalr_sum & ~XLEN'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT,
      OP_BGE, OP_BLTU, OP_BGEU: begin
        is_cf      = 1'b1;
        is_br      = 1'b1;
        act_taken  = res_cond;
        act_target = res_cond ? pc_imm : pc_4;
      end
      default: ;
    endcase
  end

  // An empty queue stands in for a not-taken, fall-through prediction.
  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CW'(DEPTH));
  assign head_taken  = !empty && taken_mem[rptr_q];
  assign head_target = empty ? pc_4 : target_mem[rptr_q];

  assign wrong = (act_taken != head_taken) ||
                 (act_taken && (act_target != head_target));

  assign res_ready  = (state_q == S_IDLE);
  assign pred_ready = !full;
  assign q_count    = cnt_q;

  assign accept = res_valid && res_ready && is_cf;
  assign report = (state_q == S_REPORT);
  assign clear  = report && wrong_q;
  assign pop    = accept && !empty;
  assign push   = pred_valid && (!full || pop) && !clear;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_REPORT;
      S_REPORT: state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      wrong_q    <= 1'b0;
      cond_q     <= 1'b0;
      redirect_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wrong_q <= wrong;
        cond_q  <= is_br;
        if (wrong) redirect_q <= act_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      taken_mem[wptr_q]  <= pred_taken;
      target_mem[wptr_q] <= pred_target;
    end
  end

  // Jumps still redirect but never train the conditional counter.
  assign predict_ok     = report && cond_q && !wrong_q;
  assign mispredict     = report && cond_q && wrong_q;
  assign redirect_write = report && wrong_q;
  assign pipe_flush     = report && wrong_q;
  assign redirect_pc    = redirect_q;

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit, the feedback end of the branch prediction unit. It records each prediction the BPU issues at fetch in a small in-order queue. When execute resolves a control-flow instruction, it compares the actual outcome and target against the oldest queued prediction. It then returns single-cycle `predict_ok` / `mispredict` pulses to the BPU's saturating counter and, on a wrong prediction, redirects the PC and flushes the front end.

## Interface
Parameters:
- `XLEN`, `core_config_pkg::XLEN` (32): address/data width.
- `DEPTH`, 4: prediction queue entries (power of two, ≥2).

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `pred_valid` in 1: BPU issued a prediction for a control-flow instruction this cycle.
- `pred_taken` in 1: predicted taken.
- `pred_target` in XLEN: predicted next PC (the fall-through PC when not taken).
- `pred_ready` out 1: queue not full.
- `res_valid` in 1: execute presents an instruction for resolution.
- `res_instr` in `opcodes_t`: decoded opcode.
- `res_pc`, `res_imm`, `res_rs1` in XLEN each: instruction PC, sign-extended immediate, rs1 value.
- `res_cond` in 1: ALU branch-condition result.
- `res_ready` out 1: resolver can accept a resolution.
- `predict_ok` out 1: conditional branch was predicted correctly (one-cycle pulse).
- `mispredict` out 1: conditional branch was predicted wrongly (one-cycle pulse).
- `redirect_pc` out XLEN: corrected PC.
- `redirect_write` out 1: load `redirect_pc` into the PC (one-cycle pulse).
- `pipe_flush` out 1: active-high flush of fetch/decode (one-cycle pulse).
- `q_count` out $clog2(DEPTH)+1: queue occupancy.

## Operation
- Queue: in-order FIFO of {taken, target}. Push on `pred_valid && pred_ready`; pointers wrap modulo DEPTH. When full, `pred_ready`=0 and the push is dropped.
- Resolution accept: `res_valid && res_ready` with `res_instr` in {JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU}. Any other opcode is ignored: no pop, no FSM transition.
- Actual outcome:
  - JAL: taken; target `res_pc+res_imm`.
  - JALR: taken; target `(res_rs1+res_imm) & ~1`.
  - Bxx: taken = `res_cond`; target is `res_pc+res_imm` if taken, else `res_pc+4`.
  - All adds are signed, modulo 2^XLEN.
- Compare against the queue head, which is popped on accept. An empty queue counts as a prediction of {not taken, `res_pc+4`}.
- Wrong = taken mismatch, or both taken with target mismatch.
- FSM states: IDLE, REPORT, GAP.
  - IDLE → REPORT on accept. Outcome and target are registered.
  - REPORT, one cycle:
    - Conditional branch: `predict_ok`=1 if right, `mispredict`=1 if wrong.
    - JAL/JALR: neither pulse, because the counter tracks conditional branches only.
    - If wrong (any type): `redirect_write`=1, `pipe_flush`=1, `redirect_pc` = actual target. The whole queue is cleared, since all younger entries are wrong-path.
    - REPORT → GAP unconditionally.
  - GAP, one cycle: all pulse outputs low, so the BPU counter re-arms. GAP → IDLE.
- `res_ready` = 1 only in IDLE.
- `redirect_pc` holds its last value outside REPORT.
- Simultaneous push and pop: both take effect and the count is unchanged. A push while the queue is full and a pop is happening in the same cycle is accepted.
- A push in the same cycle as the REPORT-wrong clear is discarded; the queue ends empty.

## Timing
- Reset values: queue empty, `q_count`=0, FSM=IDLE, `pred_ready`=1, `res_ready`=1.
  - `predict_ok`, `mispredict`, `redirect_write`, `pipe_flush` = 0.
  - `redirect_pc` = 0.
- Latency: accept at edge N → pulses visible during cycle N+1 → all pulses low during cycle N+2 → `res_ready` high in cycle N+3.
- `predict_ok` and `mispredict` are never high in the same cycle. Consecutive pulses are separated by at least one cycle in which both are low.
- `pred_ready` and `q_count` reflect registered state; they do not combinationally depend on `pred_valid`.
- Reset asserted in any state returns all state to reset values on the next edge. Any REPORT pulses in progress are suppressed.

## Test plan
- Push {taken=1, 0x100}. Then resolve BEQ at pc=0xF0, imm=0x10, cond=1. Required: `predict_ok` pulse one cycle after accept; no redirect; `q_count` 1→0.
- Push {taken=1, 0x100}. Then resolve BNE at pc=0xF0, cond=0. Required: `mispredict` pulse; `redirect_write`=1 and `pipe_flush`=1 in the same cycle; `redirect_pc`=0xF4.
- Push 3 predictions. Then resolve JALR with rs1=0x2003, imm=4, head target 0x1000. Required: redirect to 0x2006; no `predict_ok`/`mispredict`; `q_count`=0 afterwards.
- Fill all 4 entries. Required: `pred_ready`=0 and a 5th push is dropped. Then push and resolve-pop in the same cycle: `q_count` stays 4, and pointer wrap-around preserves FIFO order over 8 correct resolutions.
- Two back-to-back correct BLTs with `res_valid` held high. Required: `res_ready` low for 2 cycles after each accept; exactly two `predict_ok` pulses, separated by a zero cycle.
- Assert `rst` during REPORT of a mispredict. Required: all pulse outputs are 0 on the next cycle, `q_count`=0, and `res_ready`=1.
